// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - icache line refill controller: TTL victim select, burst fill over the flush port
// Optional: ICACHE_REFILL_CRITICAL_FIRST_EN starts the fill at the missed word and wraps through the line.
module icache_refill_ctrl #(
  parameter int DATABITS      = 32,
  parameter int ADDRBITS      = 32,
  parameter int CACHEADDRBITS = 5,
  parameter int BANKNUM       = 4,
  parameter int TTLBITS       = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDRBITS-1:0]        icache_addr,
  input  logic                       icache_rdreq,
  input  logic [BANKNUM-1:0]         line_miss,
  input  logic [BANKNUM*TTLBITS-1:0] line_ttl,
  output logic [BANKNUM-1:0]         flush_mode,
  output logic                       flush_we,
  output logic [ADDRBITS-1:0]        flush_addr,
  output logic [DATABITS-1:0]        flush_in,
  output logic [ADDRBITS-1:0]        mem_addr,
  output logic                       mem_rdreq,
  input  logic [DATABITS-1:0]        mem_data_in,
  input  logic                       mem_valid,
  output logic                       refill_busy
);

  localparam int HIBITS = ADDRBITS - CACHEADDRBITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                   state;
  logic [HIBITS-1:0]        base_hi;
  logic [CACHEADDRBITS-1:0] wcnt;
  logic [CACHEADDRBITS-1:0] wcnt_nxt;
  logic [CACHEADDRBITS-1:0] start_idx;
  logic [CACHEADDRBITS-1:0] miss_idx;
  logic [BANKNUM-1:0]       victim_oh;
  logic [TTLBITS-1:0]       best_ttl;
  logic                     miss;
  logic                     last_word;
  logic                     addr_unused;

  // Strict '>' keeps the lowest index on TTL ties.
  always_comb begin
    victim_oh    = '0;
    victim_oh[0] = 1'b1;
    best_ttl     = line_ttl[0 +: TTLBITS];
    for (int i = 1; i < BANKNUM; i++) begin
      if (line_ttl[i*TTLBITS +: TTLBITS] > best_ttl) begin
        best_ttl     = line_ttl[i*TTLBITS +: TTLBITS];
        victim_oh    = '0;
        victim_oh[i] = 1'b1;
      end
    end
  end

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  logic [CACHEADDRBITS-1:0] start_q;
  assign miss_idx    = icache_addr[CACHEADDRBITS+1:2];
  assign start_idx   = start_q;
  assign addr_unused = ^icache_addr[1:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      start_q <= '0;
    else if (miss)
      start_q <= miss_idx;
  end
`else
  assign miss_idx    = '0;
  assign start_idx   = '0;
  assign addr_unused = ^icache_addr[CACHEADDRBITS+1:0];
`endif

  assign miss      = (state == IDLE) && icache_rdreq && (&line_miss);
  assign wcnt_nxt  = wcnt + 1'b1;
  assign last_word = (wcnt_nxt == start_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base_hi     <= '0;
      wcnt        <= '0;
      flush_mode  <= '0;
      flush_we    <= 1'b0;
      flush_addr  <= '0;
      flush_in    <= '0;
      mem_addr    <= '0;
      mem_rdreq   <= 1'b0;
      refill_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state       <= FILL;
            base_hi     <= icache_addr[ADDRBITS-1:CACHEADDRBITS+2];
            wcnt        <= miss_idx;
            flush_mode  <= victim_oh;
            mem_rdreq   <= 1'b1;
            mem_addr    <= {icache_addr[ADDRBITS-1:CACHEADDRBITS+2], miss_idx, 2'b00};
            refill_busy <= 1'b1;
          end
        end
        FILL: begin
          flush_we <= 1'b0;
          if (mem_rdreq) begin
            if (mem_valid) begin
              flush_we   <= 1'b1;
              flush_in   <= mem_data_in;
              flush_addr <= {base_hi, wcnt, 2'b00};
              wcnt       <= wcnt_nxt;
              mem_addr   <= {base_hi, wcnt_nxt, 2'b00};
              if (last_word)
                mem_rdreq <= 1'b0;
            end
          end else begin
            // Final write pulse has been presented; release the victim line.
            state      <= DONE;
            flush_mode <= '0;
          end
        end
        DONE: begin
          state       <= IDLE;
          refill_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] icache_addr;
  logic        icache_rdreq;
  logic [3:0]  line_miss;
  logic [31:0] line_ttl;
  logic [3:0]  flush_mode;
  logic        flush_we;
  logic [31:0] flush_addr;
  logic [31:0] flush_in;
  logic [31:0] mem_addr;
  logic        mem_rdreq;
  logic [31:0] mem_data_in;
  logic        mem_valid;
  logic        refill_busy;

  int n_checks = 0;
  int n_errors = 0;

  icache_refill_ctrl dut (
    .clk(clk), .reset_n(reset_n), .icache_addr(icache_addr), .icache_rdreq(icache_rdreq),
    .line_miss(line_miss), .line_ttl(line_ttl), .flush_mode(flush_mode), .flush_we(flush_we),
    .flush_addr(flush_addr), .flush_in(flush_in), .mem_addr(mem_addr), .mem_rdreq(mem_rdreq),
    .mem_data_in(mem_data_in), .mem_valid(mem_valid), .refill_busy(refill_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ (a * 32'd7);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".mode"},  flush_mode, 4'h0);
    check({tag, ".we"},    flush_we, 1'b0);
    check({tag, ".rdreq"}, mem_rdreq, 1'b0);
    check({tag, ".busy"},  refill_busy, 1'b0);
  endtask

  // Issues a miss, then serves memory with 'waits' idle cycles per word and checks every write.
  // abort_at > 0 pulls reset after that many words have been written.
  task automatic run_fill(input logic [31:0] addr, input logic [31:0] ttl, input logic [3:0] exp_mode,
                          input int waits, input int abort_at);
    logic [31:0] base;
    int start, nreq, nwr, wc, cyc;
    base  = {addr[31:7], 7'b0};
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    start = int'(addr[6:2]);
`else
    start = 0;
`endif
    nreq = 0; nwr = 0; wc = 0; cyc = 0;
    @(negedge clk);
    icache_addr = addr; line_ttl = ttl; line_miss = 4'hF; icache_rdreq = 1'b1;
    @(negedge clk);
    icache_rdreq = 1'b0; line_miss = 4'h0; line_ttl = 32'h0;
    check("start.busy", refill_busy, 1'b1);
    check("start.mode", flush_mode, exp_mode);
    check("start.rdreq", mem_rdreq, 1'b1);
    while (1) begin
      if (flush_we) begin
        check("wr.addr", flush_addr, base + 32'(((start + nwr) % 32) * 4));
        check("wr.data", flush_in, mem_word(base + 32'(((start + nwr) % 32) * 4)));
        nwr++;
        if (abort_at > 0 && nwr == abort_at) begin
          reset_n = 1'b0; mem_valid = 1'b0;
          #1;
          check_idle_outputs("abort");
          check("abort.addr", mem_addr, 32'h0);
          check("abort.faddr", flush_addr, 32'h0);
          check("abort.fin", flush_in, 32'h0);
          @(negedge clk);
          reset_n = 1'b1;
          return;
        end
      end
      if (!mem_rdreq) break;
      check("fill.mode", flush_mode, exp_mode);
      check("fill.maddr", mem_addr, base + 32'(((start + nreq) % 32) * 4));
      if (wc == waits) begin
        mem_valid = 1'b1; mem_data_in = mem_word(mem_addr); wc = 0; nreq++;
      end else begin
        mem_valid = 1'b0; mem_data_in = 32'hDEAD_BEEF; wc++;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        check("fill.timeout", 1'b1, 1'b0);
        break;
      end
    end
    mem_valid = 1'b0;
    check("fill.nwr", 64'(nwr), 64'd32);
    check("fill.last_mode", flush_mode, exp_mode);
    @(negedge clk);
    check("done.mode", flush_mode, 4'h0);
    check("done.we", flush_we, 1'b0);
    check("done.busy", refill_busy, 1'b1);
    @(negedge clk);
    check("idle.busy", refill_busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; icache_addr = '0; icache_rdreq = 1'b0; line_miss = '0; line_ttl = '0;
    mem_data_in = '0; mem_valid = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset.maddr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Victim line1 (tie between lines 1 and 2), memory streams every clock.
    run_fill(32'h0000_1234, {8'd5, 8'd9, 8'd9, 8'd2}, 4'b0010, 0, 0);
    // Three wait cycles per word.
    run_fill(32'h0000_1234, {8'd5, 8'd9, 8'd9, 8'd2}, 4'b0010, 3, 0);
    // Tie between lines 0 and 3 goes to line0; unique max picks line3.
    run_fill(32'h0000_ABC0, {8'd7, 8'd1, 8'd3, 8'd7}, 4'b0001, 1, 0);
    run_fill(32'h8000_0004, {8'd200, 8'd1, 8'd3, 8'd7}, 4'b1000, 0, 0);

    // Line0 hits: no refill; stray mem_valid ignored.
    @(negedge clk);
    icache_addr = 32'h0000_1234; line_ttl = 32'h0102_0304; line_miss = 4'hE; icache_rdreq = 1'b1;
    mem_valid = 1'b1; mem_data_in = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("hit");
    end
    icache_rdreq = 1'b0; mem_valid = 1'b0;

    // Reset after word 10, then a fresh miss restarts from the beginning.
    run_fill(32'h0000_1234, {8'd5, 8'd9, 8'd9, 8'd2}, 4'b0010, 0, 10);
    check_idle_outputs("post_abort");
    run_fill(32'h0000_1234, {8'd1, 8'd9, 8'd9, 8'd2}, 4'b0010, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
